// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: switch capture on btnR, LED commit on btnL, pollable ready flags.
// Optional button debounce is enabled by defining MMIO_IO_DEBOUNCE_EN; otherwise buttons use the 2-FF synchroniser only.
module mmio_io_responder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SW_W            = 16,
  parameter int LED_W           = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pRead,
  input  logic             pWrite,
  input  logic [1:0]       addr,
  input  logic [LED_W-1:0] pWriteData,
  output logic [31:0]      pReadData,
  input  logic             buttonL,
  input  logic             buttonR,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led
);

  localparam logic [1:0] ADDR_STATUS  = 2'b00;
  localparam logic [1:0] ADDR_LEDDATA = 2'b01;
  localparam logic [1:0] ADDR_SWDATA  = 2'b10;

  // Button vectors: bit 0 is L, bit 1 is R.
  logic [1:0]      btn_s1_q, btn_s2_q;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  logic [1:0]      btn_acc;
  logic [1:0]      prev_q, prev_d;
  logic [1:0]      armed_q, armed_d;
  logic [1:0]      settle_q, settle_d;
  logic [1:0]      rise;

  logic [LED_W-1:0] led_buf_q, led_buf_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_latch_q, sw_latch_d;
  logic             sw_ready_q, sw_ready_d;
  logic             led_ready_q, led_ready_d;

  logic wr_led, rd_sw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= {buttonR, buttonL};
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= switch;
      sw_s2_q  <= sw_s1_q;
    end
  end

`ifdef MMIO_IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            acc_q, acc_d;

  // The counter tracks consecutive samples disagreeing with the accepted level;
  // agreement restarts it, and the >= guard keeps it from ever wrapping.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        acc_d[i] = btn_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign btn_acc = acc_q;
`else
  logic unused_debounce;
  assign unused_debounce = |DEBOUNCE_CYCLES;
  assign btn_acc = btn_s2_q;
`endif

  // A button only arms once the synchroniser has refilled after reset and the
  // button is seen released, so a press held across reset raises no event.
  always_comb begin
    settle_d = {settle_q[0], 1'b1};
    prev_d   = btn_acc;
    armed_d  = armed_q | ({2{settle_q[1]}} & ~btn_s2_q & ~btn_acc);
    rise     = btn_acc & ~prev_q & armed_q;
  end

  assign wr_led = pWrite && (addr == ADDR_LEDDATA);
  assign rd_sw  = pRead && (addr == ADDR_SWDATA);

  // Event assignments come last so a set beats a same-cycle clear, and led
  // always takes the buffer value from before any same-cycle write.
  always_comb begin
    led_buf_d   = led_buf_q;
    led_d       = led_q;
    sw_latch_d  = sw_latch_q;
    sw_ready_d  = sw_ready_q;
    led_ready_d = led_ready_q;
    if (wr_led) begin
      led_buf_d   = pWriteData;
      led_ready_d = 1'b0;
    end
    if (rd_sw) sw_ready_d = 1'b0;
    if (rise[1]) begin
      sw_latch_d = sw_s2_q;
      sw_ready_d = 1'b1;
    end
    if (rise[0]) begin
      led_d       = led_buf_q;
      led_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      armed_q     <= '0;
      settle_q    <= '0;
      led_buf_q   <= '0;
      led_q       <= '0;
      sw_latch_q  <= '0;
      sw_ready_q  <= 1'b0;
      led_ready_q <= 1'b1;
    end else begin
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
      led_buf_q   <= led_buf_d;
      led_q       <= led_d;
      sw_latch_q  <= sw_latch_d;
      sw_ready_q  <= sw_ready_d;
      led_ready_q <= led_ready_d;
    end
  end

  always_comb begin
    pReadData = '0;
    if (pRead) begin
      case (addr)
        ADDR_STATUS: pReadData[1:0]      = {sw_ready_q, led_ready_q};
        ADDR_SWDATA: pReadData[SW_W-1:0] = sw_latch_q;
        default:     pReadData           = '0;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder with a small register model and an expected-value queue.
// Works with MMIO_IO_DEBOUNCE_EN defined (DEBOUNCE_CYCLES=4) or undefined.
module tb_mmio_io_responder;

  localparam int SW_W  = 16;
  localparam int LED_W = 12;
`ifdef MMIO_IO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             pRead, pWrite;
  logic [1:0]       addr;
  logic [LED_W-1:0] pWriteData;
  logic [31:0]      pReadData;
  logic             buttonL, buttonR;
  logic [SW_W-1:0]  switch;
  logic [LED_W-1:0] led;

  mmio_io_responder #(
    .DEBOUNCE_CYCLES(4),
    .SW_W(SW_W),
    .LED_W(LED_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pRead(pRead),
    .pWrite(pWrite),
    .addr(addr),
    .pWriteData(pWriteData),
    .pReadData(pReadData),
    .buttonL(buttonL),
    .buttonR(buttonR),
    .switch(switch),
    .led(led)
  );

  always #5 clk = ~clk;

  // Reference model of the programmer-visible state
  logic [LED_W-1:0] m_led, m_led_buf;
  logic [SW_W-1:0]  m_sw_latch;
  logic             m_sw_ready, m_led_ready;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_led       = '0;
    m_led_buf   = '0;
    m_sw_latch  = '0;
    m_sw_ready  = 1'b0;
    m_led_ready = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'b00:   return {30'b0, m_sw_ready, m_led_ready};
      2'b10:   return {{(32-SW_W){1'b0}}, m_sw_latch};
      default: return 32'h0;
    endcase
  endfunction

  // Called at a negedge; the read completes at the following posedge.
  task automatic cpu_read(input logic [1:0] a, input string tag);
    logic [31:0] e;
    pRead = 1'b1;
    addr  = a;
    exp_q.push_back(model_read(a));
    #1;
    e = exp_q.pop_front();
    check_val(tag, pReadData, e);
    @(negedge clk);
    pRead = 1'b0;
    if (a == 2'b10 && !reset) m_sw_ready = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [LED_W-1:0] d);
    pWrite     = 1'b1;
    addr       = a;
    pWriteData = d;
    @(negedge clk);
    pWrite = 1'b0;
    if (a == 2'b01) begin
      m_led_buf   = d;
      m_led_ready = 1'b0;
    end
  endtask

  task automatic check_led(input string tag);
    #1;
    check_val(tag, 32'(led), 32'(m_led));
  endtask

  task automatic press_r(input int hold);
    buttonR = 1'b1;
    tick(hold);
    buttonR = 1'b0;
    tick(12);
    m_sw_latch = switch;
    m_sw_ready = 1'b1;
  endtask

  task automatic press_l(input int hold);
    buttonL = 1'b1;
    tick(hold);
    buttonL = 1'b0;
    tick(12);
    m_led       = m_led_buf;
    m_led_ready = 1'b1;
  endtask

  logic [LED_W-1:0] old_buf;

  initial begin
    reset = 1'b1; pRead = 1'b0; pWrite = 1'b0; addr = 2'b00; pWriteData = '0;
    buttonL = 1'b0; buttonR = 1'b0; switch = '0;
    model_reset();
    tick(2);
    reset = 1'b0;
    tick(4);

    // Reset state
    check_led("rst_led");
    cpu_read(2'b00, "rst_status");
    cpu_read(2'b10, "rst_swdata");

    // Switch capture
    switch = 16'hA5C3;
    tick(3);
    press_r(10);
    cpu_read(2'b00, "cap_status");
    cpu_read(2'b10, "cap_swdata");
    cpu_read(2'b00, "cap_status_after");

    // LED commit
    cpu_write(2'b01, 12'h7E1);
    cpu_read(2'b00, "led_wr_status");
    check_led("led_wr_led");
    press_l(10);
    check_led("led_commit_led");
    cpu_read(2'b00, "led_commit_status");

    // Debounce: 2-cycle toggling filtered only when debounce is built in
    switch = 16'($urandom_range(0, 16'hFFFF));
    tick(3);
    for (int i = 0; i < 20; i++) begin
      buttonR = ~buttonR;
      tick(2);
    end
    tick(12);
`ifndef MMIO_IO_DEBOUNCE_EN
    m_sw_latch = switch;
    m_sw_ready = 1'b1;
`endif
    cpu_read(2'b00, "toggle_status");
    cpu_read(2'b10, "toggle_swdata");
    switch = 16'($urandom_range(0, 16'hFFFF));
    tick(3);
    buttonR = 1'b1;
    tick(8);
    m_sw_latch = switch;
    m_sw_ready = 1'b1;
    cpu_read(2'b00, "hold_status");
    cpu_read(2'b10, "hold_swdata");
    tick(6);
    cpu_read(2'b00, "hold_single_event");
    buttonR = 1'b0;
    tick(12);

    // Collision: R event on the same edge as an SWDATA read
    switch = 16'h3C5A;
    tick(3);
    buttonR = 1'b1;
    tick(LAT);
    cpu_read(2'b10, "coll_r_read");
    m_sw_latch = 16'h3C5A;
    m_sw_ready = 1'b1;
    cpu_read(2'b00, "coll_r_status");
    buttonR = 1'b0;
    tick(12);
    cpu_read(2'b10, "coll_r_swdata");

    // Collision: L event on the same edge as a LEDDATA write
    old_buf = m_led_buf;
    buttonL = 1'b1;
    tick(LAT);
    cpu_write(2'b01, 12'h123);
    m_led       = old_buf;
    m_led_ready = 1'b1;
    check_led("coll_l_led");
    cpu_read(2'b00, "coll_l_status");
    buttonL = 1'b0;
    tick(12);
    press_l(10);
    check_led("coll_l_newbuf");

    // Unmapped and ignored accesses
    cpu_write(2'b11, 12'hFFF);
    cpu_write(2'b00, 12'hFFF);
    check_led("unmap_led");
    cpu_read(2'b00, "unmap_status");
    cpu_read(2'b11, "unmap_read11");
    press_r(10);
    pRead = 1'b0;
    addr  = 2'b10;
    #1;
    check_val("no_pread_zero", pReadData, 32'h0);
    @(negedge clk);
    cpu_read(2'b10, "unmap_swdata");

    // Mid-cycle reset with buttonR held across it
    buttonR = 1'b1;
    tick(10);
    #3;
    reset = 1'b1;
    model_reset();
    check_led("midrst_led");
    @(negedge clk);
    cpu_read(2'b00, "midrst_status");
    cpu_read(2'b10, "midrst_swdata");
    reset = 1'b0;
    tick(15);
    cpu_read(2'b00, "held_no_event");
    buttonR = 1'b0;
    tick(12);
    switch = 16'h0F0F;
    tick(3);
    press_r(10);
    cpu_read(2'b00, "repress_status");
    cpu_read(2'b10, "repress_swdata");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
